// File: rtl/code_ram_loader.sv
// Dual-role instruction RAM: a registered CPU fetch port plus a byte-stream loader
// that assembles MSB-first words and writes them from a base address.
module code_ram_loader #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_en,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    input  logic              load_start,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [ADDR_W:0]   load_len,
    input  logic [7:0]        load_byte,
    input  logic              load_byte_valid,
    output logic              load_byte_ready,
    output logic              load_busy,
    output logic              load_done
);

    localparam int unsigned Bytes = DATA_W / 8;
    localparam int unsigned BcntW = (Bytes > 1) ? $clog2(Bytes) : 1;
    localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] OneWord = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StCollect, StWrite, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [BcntW-1:0]  bcnt_q, bcnt_d;
    logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              mem_we;

    // Not reset: program contents must survive a reset.
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            ptr_q         <= '0;
            cnt_q         <= '0;
            word_q        <= '0;
            bcnt_q        <= '0;
            fetch_data_q  <= '0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            word_q        <= word_d;
            bcnt_q        <= bcnt_d;
            fetch_data_q  <= fetch_data_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    // Nonblocking write against a combinational read gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[ptr_q] <= word_q;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        bcnt_d  = bcnt_q;
        unique case (state_q)
            StIdle: begin
                if (load_start) begin
                    ptr_d   = load_base;
                    cnt_d   = (load_len > MaxLen) ? MaxLen : load_len;
                    word_d  = '0;
                    bcnt_d  = '0;
                    state_d = (load_len == '0) ? StDone : StCollect;
                end
            end
            StCollect: begin
                if (load_byte_valid) begin
                    word_d = (word_q << 8) | DATA_W'(load_byte);
                    if (bcnt_q == BcntW'(Bytes - 1)) begin
                        bcnt_d  = '0;
                        state_d = StWrite;
                    end else begin
                        bcnt_d = bcnt_q + 1'b1;
                    end
                end
            end
            StWrite: begin
                ptr_d   = ptr_q + 1'b1;
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == OneWord) ? StDone : StCollect;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        fetch_valid_d = fetch_en;
        fetch_data_d  = fetch_en ? mem[fetch_addr] : fetch_data_q;
    end

    always_comb begin
        load_byte_ready = (state_q == StCollect);
        load_busy       = (state_q != StIdle);
        load_done       = (state_q == StDone);
        mem_we          = (state_q == StWrite);
        fetch_data      = fetch_data_q;
        fetch_valid     = fetch_valid_q;
    end

endmodule
